// File: rtl/gpio_in_debounce.sv
// Synchronizes WIDTH asynchronous switch inputs and debounces each bit with a
// per-bit stability counter; emits clean levels, edge pulses and a settled flag.
module gpio_in_debounce #(
  parameter int unsigned     WIDTH         = 16,
  parameter int unsigned     SYNC_STAGES   = 2,
  parameter int unsigned     STABLE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o,
  output logic             stable_o
);

  localparam int unsigned   CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  logic             stable_q, stable_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= raw_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Any sample agreeing with the current level restarts qualification.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != db_q[i]) begin
        if (cnt_q[i] == LAST) begin
          db_d[i]   = sync[i];
          rise_d[i] = sync[i];
          fall_d[i] = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    chg_d    = |(rise_d | fall_d);
    stable_d = (sync == db_q);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      db_q     <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      chg_q    <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      chg_q    <= chg_d;
      stable_q <= stable_d;
    end
  end

  assign db_o     = db_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign chg_o    = chg_q;
  assign stable_o = stable_q;

endmodule
